// File: rtl/ext_bus_sequencer.sv
// External memory bus sequencer: multiplexes one core access at a time onto the
// TinyTapeout pins as ADDR_HI / ADDR_LO / DATA phases. Optional DATA-phase timeout: EXT_BUS_TIMEOUT_EN.
module ext_bus_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    input  logic        ext_rdy,
    output logic [7:0]  pin_out,
    input  logic [7:0]  pio_in,
    output logic [7:0]  pio_out,
    output logic [7:0]  pio_oe
);

    // state   | meaning
    // IDLE    | pins released, ready for a request
    // ADDR_HI | address high byte on pin_out, pio_out[1] marks the phase
    // ADDR_LO | address low byte on pin_out
    // DATA    | data transfer; waits while ext_rdy is low
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR_HI = 2'd1,
        ADDR_LO = 2'd2,
        DATA    = 2'd3
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] addr_q;
    logic        rw_q;
    logic [7:0]  wdata_q;
    logic        accept;
    logic        done;
    logic        abort;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign done      = (state == DATA) && ext_rdy;

`ifdef EXT_BUS_TIMEOUT_EN
    logic [7:0] wait_cnt;

    assign abort = (state == DATA) && !ext_rdy && (wait_cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (state == ADDR_LO) begin
            wait_cnt <= 8'd0;
        end else if ((state == DATA) && !ext_rdy) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    logic unused_timeout;

    assign abort          = 1'b0;
    assign unused_timeout = ^TO_LAST;
`endif

    // Request fields are captured on the accepting edge only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= 16'd0;
            rw_q    <= 1'b0;
            wdata_q <= 8'd0;
        end else if (accept) begin
            addr_q  <= req_addr;
            rw_q    <= req_rw;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ADDR_HI;
            ADDR_HI: state_nxt = ADDR_LO;
            ADDR_LO: state_nxt = DATA;
            DATA:    if (done || abort) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 8'd0;
        end else begin
            rsp_valid <= done || abort;
            rsp_err   <= abort;
            if (done && rw_q) begin
                rsp_rdata <= pio_in;
            end else if (abort) begin
                rsp_rdata <= 8'hFF;
            end
        end
    end

    always_comb begin
        pin_out = 8'h00;
        pio_out = 8'h00;
        pio_oe  = 8'h00;
        case (state)
            ADDR_HI: begin
                pin_out = addr_q[15:8];
                pio_out = {6'b0, 1'b1, rw_q};
                pio_oe  = 8'hFF;
            end
            ADDR_LO: begin
                pin_out = addr_q[7:0];
                pio_out = {6'b0, 1'b0, rw_q};
                pio_oe  = 8'hFF;
            end
            DATA: begin
                pin_out = addr_q[7:0];
                if (!rw_q) begin
                    pio_out = wdata_q;
                    pio_oe  = 8'hFF;
                end
            end
            default: ;
        endcase
    end

endmodule
